// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single-port 64x8 data SRAM between the core port and the
// host/debug loader port.
// Grants are combinational; the winning command is registered onto the SRAM pins.
// Read data returns to the owning port three enabled cycles after accept.
// A bounded wait counter forces the host to win after HOST_MAX_WAIT refusals.
// Optional feature macro: SRAM_ARB_HOST_WP_EN. It write-protects host writes at or
// above WP_BASE and reports each blocked write on host_wp_err.
module sram_arbiter #(
  parameter int unsigned ADDR_W        = 6,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned HOST_MAX_WAIT = 4
`ifdef SRAM_ARB_HOST_WP_EN
  ,
  parameter logic [ADDR_W-1:0] WP_BASE = ADDR_W'(6'h30)
`endif
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              clk_valid,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              sram_write_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_out,
  input  logic [DATA_W-1:0] sram_data_in
`ifdef SRAM_ARB_HOST_WP_EN
  ,
  output logic              host_wp_err
`endif
);

  typedef enum logic {OwnCore, OwnHost} owner_e;

  logic [3:0]        host_wait_q, host_wait_d;
  logic              host_at_limit;
  logic              host_win;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              wp_block;

  // Read tag in the issue stage (SRAM pins driven) and in the return stage (data on bus).
  logic   iss_rd_q, ret_rd_q;
  owner_e iss_owner_q, ret_owner_q;

  // Arbitration: core by default, host when core is idle or the host has waited too long.
  always_comb begin
    host_at_limit = (host_wait_q == 4'(HOST_MAX_WAIT));
    host_win      = host_req && (!core_req || host_at_limit);
    host_gnt      = clk_valid && !srst && host_win;
    core_gnt      = clk_valid && !srst && core_req && !host_win;
    accept        = core_gnt || host_gnt;
    sel_we        = host_gnt ? host_we    : core_we;
    sel_addr      = host_gnt ? host_addr  : core_addr;
    sel_wdata     = host_gnt ? host_wdata : core_wdata;
`ifdef SRAM_ARB_HOST_WP_EN
    wp_block      = host_gnt && host_we && (host_addr >= WP_BASE);
`else
    wp_block      = 1'b0;
`endif
  end

  // Next host wait count: grows while refused, saturates at the limit, clears otherwise.
  always_comb begin
    host_wait_d = 4'd0;
    if (host_req && !host_gnt) begin
      host_wait_d = host_at_limit ? host_wait_q : host_wait_q + 4'd1;
    end
  end

  // Host starvation counter.
  always_ff @(posedge clk) begin
    if (srst) begin
      host_wait_q <= 4'd0;
    end else if (clk_valid) begin
      host_wait_q <= host_wait_d;
    end
  end

  // Issue stage: register the accepted command onto the SRAM pins and tag reads.
  always_ff @(posedge clk) begin
    if (srst) begin
      sram_write_en <= 1'b0;
      sram_addr     <= '0;
      sram_data_out <= '0;
      iss_rd_q      <= 1'b0;
      iss_owner_q   <= OwnCore;
    end else if (clk_valid) begin
      sram_write_en <= accept && sel_we && !wp_block;
      iss_rd_q      <= accept && !sel_we;
      iss_owner_q   <= host_gnt ? OwnHost : OwnCore;
      // Address and data hold when idle to avoid needless pin toggling.
      if (accept) begin
        sram_addr     <= sel_addr;
        sram_data_out <= sel_wdata;
      end
    end
  end

`ifdef SRAM_ARB_HOST_WP_EN
  // Protection error pulse, aligned with the cycle the write would have been issued.
  always_ff @(posedge clk) begin
    if (srst) begin
      host_wp_err <= 1'b0;
    end else if (clk_valid) begin
      host_wp_err <= wp_block;
    end
  end
`endif

  // Return stage: the SRAM drives read data during this stage.
  always_ff @(posedge clk) begin
    if (srst) begin
      ret_rd_q    <= 1'b0;
      ret_owner_q <= OwnCore;
    end else if (clk_valid) begin
      ret_rd_q    <= iss_rd_q;
      ret_owner_q <= iss_owner_q;
    end
  end

  // Capture read data for the owning port and pulse its rvalid for one enabled cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      core_rdata  <= '0;
      core_rvalid <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else if (clk_valid) begin
      core_rvalid <= ret_rd_q && (ret_owner_q == OwnCore);
      host_rvalid <= ret_rd_q && (ret_owner_q == OwnHost);
      if (ret_rd_q && (ret_owner_q == OwnCore)) begin
        core_rdata <= sram_data_in;
      end
      if (ret_rd_q && (ret_owner_q == OwnHost)) begin
        host_rdata <= sram_data_in;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural 64x8 SRAM model.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       srst, clk_valid;
  logic       core_req, core_we, core_gnt, core_rvalid;
  logic [5:0] core_addr;
  logic [7:0] core_wdata, core_rdata;
  logic       host_req, host_we, host_gnt, host_rvalid;
  logic [5:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic       sram_write_en;
  logic [5:0] sram_addr;
  logic [7:0] sram_data_out, sram_data_in;
`ifdef SRAM_ARB_HOST_WP_EN
  logic       host_wp_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk           (clk),
    .srst          (srst),
    .clk_valid     (clk_valid),
    .core_req      (core_req),
    .core_we       (core_we),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_gnt      (core_gnt),
    .core_rdata    (core_rdata),
    .core_rvalid   (core_rvalid),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_gnt      (host_gnt),
    .host_rdata    (host_rdata),
    .host_rvalid   (host_rvalid),
    .sram_write_en (sram_write_en),
    .sram_addr     (sram_addr),
    .sram_data_out (sram_data_out),
    .sram_data_in  (sram_data_in)
`ifdef SRAM_ARB_HOST_WP_EN
    ,
    .host_wp_err   (host_wp_err)
`endif
  );

  // Synchronous SRAM gated by clk_valid; read data appears one enabled cycle after address.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (clk_valid) begin
      if (sram_write_en) mem[sram_addr] <= sram_data_out;
      sram_data_in <= mem[sram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    srst = 1'b1; clk_valid = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'h00; core_wdata = 8'h00;
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'h00; host_wdata = 8'h00;

    // Reset with both requesting
    tick();
    tick();
    check_eq("rst_core_gnt", core_gnt, 0);
    check_eq("rst_host_gnt", host_gnt, 0);
    check_eq("rst_we", sram_write_en, 0);
    check_eq("rst_addr", sram_addr, 0);
    check_eq("rst_data", sram_data_out, 0);
    check_eq("rst_crv", core_rvalid, 0);
    check_eq("rst_hrv", host_rvalid, 0);
    check_eq("rst_crd", core_rdata, 0);
    srst = 1'b0;
    #1;
    check_eq("post_rst_core_gnt", core_gnt, 1);
    check_eq("post_rst_host_gnt", host_gnt, 0);
    core_req = 1'b0; host_req = 1'b0;
    tick();

    // Host write A5 -> 05, then core read back
    host_req = 1'b1; host_we = 1'b1; host_addr = 6'h05; host_wdata = 8'hA5;
    #1;
    check_eq("hw_gnt", host_gnt, 1);
    check_eq("hw_core_gnt", core_gnt, 0);
    tick();
    host_req = 1'b0;
    check_eq("hw_we", sram_write_en, 1);
    check_eq("hw_addr", sram_addr, 6'h05);
    check_eq("hw_data", sram_data_out, 8'hA5);
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'h05;
    #1;
    check_eq("cr_gnt", core_gnt, 1);
    tick();
    core_req = 1'b0;
    check_eq("cr_we_idle", sram_write_en, 0);
    check_eq("cr_rv_n1", core_rvalid, 0);
    tick();
    check_eq("cr_rv_n2", core_rvalid, 0);
    tick();
    check_eq("cr_rv_n3", core_rvalid, 1);
    check_eq("cr_rdata", core_rdata, 8'hA5);
    tick();
    check_eq("cr_rv_n4", core_rvalid, 0);
    check_eq("cr_rdata_hold", core_rdata, 8'hA5);

    // Simultaneous single requests: core first, host next
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'h05;
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'h05;
    #1;
    check_eq("sim_c0_gnt", core_gnt, 1);
    check_eq("sim_h0_gnt", host_gnt, 0);
    tick();
    core_req = 1'b0;
    #1;
    check_eq("sim_h1_gnt", host_gnt, 1);
    check_eq("sim_c1_gnt", core_gnt, 0);
    tick();
    host_req = 1'b0;
    #1;
    check_eq("sim_h2_gnt", host_gnt, 0);
    tick();
    check_eq("sim_crv", core_rvalid, 1);
    check_eq("sim_hrv_early", host_rvalid, 0);
    tick();
    check_eq("sim_crv_off", core_rvalid, 0);
    check_eq("sim_hrv", host_rvalid, 1);
    check_eq("sim_hrd", host_rdata, 8'hA5);
    tick();

    // Starvation: both held, host forced every 5th enabled cycle
    core_req = 1'b1; core_addr = 6'h00;
    host_req = 1'b1; host_addr = 6'h01;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq($sformatf("starve_h%0d", i), host_gnt, (i % 5 == 4) ? 1 : 0);
      check_eq($sformatf("starve_c%0d", i), core_gnt, (i % 5 == 4) ? 0 : 1);
      tick();
    end
    core_req = 1'b0; host_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("drain_crv", core_rvalid, 0);
    check_eq("drain_hrv", host_rvalid, 0);

    // Back-to-back write then read of same address, then clock enable gap
    core_req = 1'b1; core_we = 1'b1; core_addr = 6'h0A; core_wdata = 8'h3C;
    #1;
    check_eq("raw_w_gnt", core_gnt, 1);
    tick();
    core_we = 1'b0;
    #1;
    check_eq("raw_r_gnt", core_gnt, 1);
    check_eq("raw_we", sram_write_en, 1);
    check_eq("raw_addr", sram_addr, 6'h0A);
    check_eq("raw_data", sram_data_out, 8'h3C);
    tick();
    core_req = 1'b0; clk_valid = 1'b0;
    core_req = 1'b1;
    #1;
    check_eq("gated_gnt", core_gnt, 0);
    core_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("gated_addr%0d", i), sram_addr, 6'h0A);
      check_eq($sformatf("gated_we%0d", i), sram_write_en, 0);
      check_eq($sformatf("gated_rv%0d", i), core_rvalid, 0);
      tick();
    end
    clk_valid = 1'b1;
    tick();
    check_eq("gap_rv_e1", core_rvalid, 0);
    tick();
    check_eq("gap_rv_e2", core_rvalid, 1);
    check_eq("gap_rdata", core_rdata, 8'h3C);
    clk_valid = 1'b0;
    tick();
    check_eq("gap_rv_stretch", core_rvalid, 1);
    clk_valid = 1'b1;
    tick();
    check_eq("gap_rv_off", core_rvalid, 0);

    // Host read, then reset the next cycle: read must vanish
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'h05;
    #1;
    check_eq("rr_gnt", host_gnt, 1);
    tick();
    srst = 1'b1;
    #1;
    check_eq("rr_gnt_in_rst", host_gnt, 0);
    tick();
    srst = 1'b0; host_req = 1'b0;
    check_eq("rr_we", sram_write_en, 0);
    check_eq("rr_addr", sram_addr, 0);
    check_eq("rr_hrd", host_rdata, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rr_hrv%0d", i), host_rvalid, 0);
      tick();
    end

`ifdef SRAM_ARB_HOST_WP_EN
    // Protected host write is accepted but never reaches the SRAM
    host_req = 1'b1; host_we = 1'b1; host_addr = 6'h3F; host_wdata = 8'h77;
    #1;
    check_eq("wp_gnt", host_gnt, 1);
    tick();
    host_req = 1'b0;
    check_eq("wp_we", sram_write_en, 0);
    check_eq("wp_err", host_wp_err, 1);
    tick();
    check_eq("wp_err_off", host_wp_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter sharing the single-port 64x8 data SRAM between the control unit (core port) and a debug/host loader port (host port).
- Accepts one access per enabled cycle and registers the winner's command onto the SRAM pins.
- Returns read data to the owning requester and prevents host starvation with a bounded-wait counter.
- Sits between CU/debug logic and sram_64x8, gated by the same clk_valid enable.

Parameters:
ADDR_W, 6, SRAM address width
DATA_W, 8, SRAM data width
HOST_MAX_WAIT, 4, enabled cycles host may be refused before it is forced to win; legal range 1..15

Ports:
clk  input  1  system clock
srst  input  1  synchronous reset, active-high
clk_valid  input  1  clock enable; state advances only on clk edges where clk_valid=1 ("enabled cycles")
core_req  input  1  core access request; held with command until core_gnt
core_we  input  1  1 = write, 0 = read
core_addr  input  ADDR_W  core address
core_wdata  input  DATA_W  core write data
core_gnt  output  1  core command accepted this cycle (combinational)
core_rdata  output  DATA_W  core read data
core_rvalid  output  1  one-cycle pulse, core_rdata valid
host_req, host_we, host_addr, host_wdata  input  1/1/ADDR_W/DATA_W  same meaning for host
host_gnt  output  1  host command accepted this cycle
host_rdata  output  DATA_W  host read data
host_rvalid  output  1  one-cycle pulse, host_rdata valid
sram_write_en  output  1  SRAM write strobe (registered)
sram_addr  output  ADDR_W  SRAM address (registered)
sram_data_out  output  DATA_W  SRAM write data (registered)
sram_data_in  input  DATA_W  SRAM read data; valid one enabled cycle after sram_addr is presented

Behaviour:
- Handshake: valid/ready. Accept occurs when x_req=1 and x_gnt=1 while clk_valid=1. A requester may hold req high for back-to-back accesses.
- Gnt is combinational from req, clk_valid and registered wait counter. Both gnts are 0 when clk_valid=0 or srst=1. core_gnt and host_gnt are never both 1.
- Priority: core wins by default. Host wins when core_req=0, or when host_wait==HOST_MAX_WAIT.
- host_wait (4 bits):
  - +1 on each enabled cycle with host_req=1 and host_gnt=0.
  - Cleared on host accept or host_req=0.
  - Saturates at HOST_MAX_WAIT.
- Issue stage:
  - An accept in cycle N drives sram_addr, sram_data_out and sram_write_en=we during cycle N+1.
  - An owner tag records CORE or HOST and RD or WR.
  - With no accept in N, sram_write_en=0 in N+1; addr/data hold their last values.
- Read return:
  - SRAM data is valid in N+2 and is registered into the owner's rdata at the end of N+2.
  - x_rvalid=1 during N+3 for exactly one enabled cycle.
  - Read latency is 3 enabled cycles from accept.
  - rdata holds its value until the next read returns to that port.
  - Writes produce no rvalid.
- Pipelining: accepts may occur every enabled cycle. Up to 2 reads are in flight; return order equals accept order.
- Read-after-write to the same address, accepted in consecutive cycles, returns the new data (the SRAM write completes before the read sample).
- clk_valid=0: every register holds, including registered sram_write_en; the SRAM ignores it because it is gated by the same clk_valid. rvalid pulses extend until the next enabled cycle; pending reads are not lost.
- Reset (srst=1 at any clk edge, regardless of clk_valid):
  - All registered outputs go to 0: sram_write_en, sram_addr, sram_data_out, rdata, rvalid.
  - host_wait=0 and in-flight reads are discarded; no rvalid follows for reads accepted before reset.
  - gnt is 0 while srst=1.

Optional Feature:
- Macro SRAM_ARB_HOST_WP_EN.
- Defined:
  - Adds parameter WP_BASE (default 6'h30) and output host_wp_err (1 bit, registered, reset 0).
  - A host write accepted to address >= WP_BASE is accepted (host_gnt=1) but issues sram_write_en=0.
  - host_wp_err pulses 1 during N+1. Core writes are unaffected.
- Undefined: no port or parameter; all host writes reach the SRAM.

Test Plan:
- srst=1 for 2 cycles with core_req=host_req=1 -> both gnt=0, all outputs 0. First enabled cycle after release -> core_gnt=1.
- Host write 0xA5 to 0x05 (core idle) -> host_gnt same cycle; next cycle sram_write_en=1, sram_addr=0x05, sram_data_out=0xA5. Then core read 0x05 -> core_rvalid 3 enabled cycles after accept, core_rdata=0xA5.
- core_req and host_req rise together, single requests each -> core accepted cycle 0, host accepted cycle 1, single-cycle gnt each.
- core_req held high continuously, host_req held, HOST_MAX_WAIT=4 -> host_gnt=1 in 5th enabled cycle only, core_gnt=0 that cycle. host_wait cleared, pattern repeats every 5 cycles.
- Core read accepted, then clk_valid=0 for 3 cycles -> no state change. core_rvalid appears after 3 further enabled cycles with correct data.
- Host read accepted, srst=1 in the next cycle -> no host_rvalid ever; sram_write_en=0. With SRAM_ARB_HOST_WP_EN: host write 0x3F -> sram_write_en=0, host_wp_err=1 one cycle.
